// File: rtl/delay_line_gea1.sv
// delay_line_gea1: multi-bit delay line with a run-time tap (0..MAX_DEPTH) and per-stage valid.
// Optional build macro DELAY_GEA1_SEL_FLUSH_EN registers sel and flushes all valids on a tap change.
module delay_line_gea1 #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 8,
  parameter int SELW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic             a_vld,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] y,
  output logic             y_vld
);

  logic [WIDTH-1:0]   s [1:MAX_DEPTH];
  logic [MAX_DEPTH:1] v;
  logic [SELW-1:0]    tap_sel;
  logic [SELW-1:0]    d;

`ifdef DELAY_GEA1_SEL_FLUSH_EN
  logic [SELW-1:0] sel_q;

  // Loading sel every cycle is equivalent to loading only when it differs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= '0;
    else     sel_q <= sel;
  end

  assign tap_sel = sel_q;
`else
  assign tap_sel = sel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i <= MAX_DEPTH; i++) s[i] <= '0;
      v <= '0;
    end else begin
      if (en) begin
        s[1] <= a;
        v[1] <= a_vld;
        for (int unsigned i = 2; i <= MAX_DEPTH; i++) begin
          s[i] <= s[i-1];
          v[i] <= v[i-1];
        end
      end
`ifdef DELAY_GEA1_SEL_FLUSH_EN
      // A tap change invalidates everything in flight, including the sample entering now.
      if (sel != sel_q) v <= '0;
`endif
    end
  end

  always_comb begin
    d = (tap_sel > SELW'(MAX_DEPTH)) ? SELW'(MAX_DEPTH) : tap_sel;
    y     = a;
    y_vld = a_vld;
    for (int unsigned i = 1; i <= MAX_DEPTH; i++) begin
      if (d == SELW'(i)) begin
        y     = s[i];
        y_vld = v[i];
      end
    end
  end

endmodule

// File: tb/tb_delay_line_gea1.sv
// Self-checking bench for delay_line_gea1: directed literal checks plus randomized
// stimulus compared every cycle against a queue-based history model.
module tb_delay_line_gea1;
  localparam int WIDTH     = 8;
  localparam int MAX_DEPTH = 8;
  localparam int SELW      = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic             a_vld = 1'b0;
  logic [SELW-1:0]  sel = '0;
  logic [WIDTH-1:0] y;
  logic             y_vld;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  delay_line_gea1 #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .a_vld(a_vld), .sel(sel), .y(y), .y_vld(y_vld)
  );

  always #5 clk = ~clk;

  // Model: hist[k] is the (k+1)-th most recent enabled sample since reset.
  typedef struct { logic [WIDTH-1:0] data; logic vld; } samp_t;
  samp_t hist[$];
  int    m_selq = 0;

  task automatic model_clear();
    samp_t z;
    z.data = '0;
    z.vld  = 1'b0;
    hist.delete();
    for (int k = 0; k < MAX_DEPTH; k++) hist.push_back(z);
    m_selq = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear();
    end else begin
      samp_t n;
      bit flush;
`ifdef DELAY_GEA1_SEL_FLUSH_EN
      flush = (int'(sel) != m_selq);
`else
      flush = 1'b0;
`endif
      if (en) begin
        n.data = a;
        n.vld  = a_vld;
        hist.push_front(n);
        void'(hist.pop_back());
      end
      if (flush) begin
        foreach (hist[k]) hist[k].vld = 1'b0;
      end
      m_selq = int'(sel);
    end
  end

  function automatic void chk(string name, logic [WIDTH-1:0] ay, logic av,
                              logic [WIDTH-1:0] ey, logic ev);
    checks++;
    if (ay !== ey || av !== ev) begin
      errors++;
      $display("FAIL %s: got y=%h y_vld=%b, expected y=%h y_vld=%b at %0t", name, ay, av, ey, ev, $time);
    end
  endfunction

  // Per-cycle compare: inputs change on negedge, outputs checked 1 time unit before posedge.
  always @(negedge clk) begin
    #4;
    if (run) begin
      int tap;
      int dd;
      logic [WIDTH-1:0] ey;
      logic ev;
`ifdef DELAY_GEA1_SEL_FLUSH_EN
      tap = m_selq;
`else
      tap = int'(sel);
`endif
      dd = (tap > MAX_DEPTH) ? MAX_DEPTH : tap;
      if (dd == 0) begin
        ey = a;
        ev = a_vld;
      end else begin
        ey = hist[dd-1].data;
        ev = hist[dd-1].vld;
      end
      chk("model", y, y_vld, ey, ev);
    end
  end

  task automatic drive(input logic e, input logic av, input logic [WIDTH-1:0] aa,
                       input logic [SELW-1:0] ss);
    @(negedge clk);
    en = e; a_vld = av; a = aa; sel = ss;
  endtask

  // Sample point for literal checks: same instant the compare process samples.
  task automatic settle();
    #4;
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run = 1'b1;

    // Reset state
    drive(1'b1, 1'b0, 8'h00, 4'd3);
    settle();
    chk("reset_state", y, y_vld, 8'h00, 1'b0);

    // Bypass at sel=0 (first returns sel to 0 and lets the tap settle)
    drive(1'b1, 1'b0, 8'h00, 4'd0);
    drive(1'b1, 1'b1, 8'hA5, 4'd0);
    settle();
    chk("bypass", y, y_vld, 8'hA5, 1'b1);

    // Fixed delay sel=5
    drive(1'b1, 1'b0, 8'h00, 4'd5);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b1, 8'(k + 1), 4'd5);
      settle();
      if (k >= 5) chk("fixed_delay5", y, y_vld, 8'(k - 4), 1'b1);
    end

    // Clamp: sel=15 behaves as an 8-cycle delay
    drive(1'b1, 1'b0, 8'h00, 4'd15);
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b1, 8'(k + 1), 4'd15);
      settle();
      if (k >= 8) chk("clamp15", y, y_vld, 8'(k - 7), 1'b1);
    end

    // Stall at sel=2
    drive(1'b1, 1'b0, 8'h00, 4'd2);
    drive(1'b1, 1'b0, 8'h00, 4'd2);
    drive(1'b1, 1'b0, 8'h00, 4'd2);
    drive(1'b1, 1'b1, 8'h10, 4'd2);
    drive(1'b1, 1'b1, 8'h11, 4'd2);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 8'hEE, 4'd2);
      settle();
      chk("stall_hold", y, y_vld, 8'h10, 1'b1);
    end
    drive(1'b1, 1'b1, 8'h12, 4'd2);
    settle();
    chk("stall_resume", y, y_vld, 8'h10, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 4'd2);
    settle();
    chk("stall_next", y, y_vld, 8'h11, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 4'd2);
    settle();
    chk("stall_last", y, y_vld, 8'h12, 1'b1);

    // Valid bubbles at sel=4: a_vld 1,0,1,1
    drive(1'b1, 1'b0, 8'h00, 4'd4);
    drive(1'b1, 1'b1, 8'h20, 4'd4);
    drive(1'b1, 1'b0, 8'h21, 4'd4);
    drive(1'b1, 1'b1, 8'h22, 4'd4);
    drive(1'b1, 1'b1, 8'h23, 4'd4);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] pat;
      pat = 4'b1101;
      drive(1'b1, 1'b0, 8'h00, 4'd4);
      settle();
      if (pat[k]) chk("bubble_data", y, y_vld, 8'(8'h20 + k), 1'b1);
      else        chk("bubble_gap", 8'h00, y_vld, 8'h00, 1'b0);
    end

    // sel change 6 -> 2 after the 0x08 entry edge
    drive(1'b1, 1'b0, 8'h00, 4'd6);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b1, 8'(k), (k >= 9) ? 4'd2 : 4'd6);
      settle();
`ifdef DELAY_GEA1_SEL_FLUSH_EN
      if (k == 10 || k == 11) chk("selchg_flush", 8'h00, y_vld, 8'h00, 1'b0);
      if (k == 12) chk("selchg_first", y, y_vld, 8'h0A, 1'b1);
`else
      if (k == 9)  chk("selchg_immediate", y, y_vld, 8'h07, 1'b1);
      if (k == 10) chk("selchg_next", y, y_vld, 8'h08, 1'b1);
`endif
    end

    // Async reset mid-cycle with the line holding data, sel=3
    drive(1'b1, 1'b0, 8'h00, 4'd3);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 8'(8'h40 + k), 4'd3);
    drive(1'b1, 1'b0, 8'h00, 4'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_reset", y, y_vld, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 4'd3);
    settle();
    chk("reset_with_en0", y, y_vld, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1; a_vld = 1'b0; a = 8'h50; sel = 4'd3;
    for (int k = 1; k < 6; k++) begin
      drive(1'b1, 1'b1, 8'(8'h50 + k), 4'd3);
      settle();
      if (k <= 3) chk("post_reset_empty", 8'h00, y_vld, 8'h00, 1'b0);
      else        chk("post_reset_first", y, y_vld, 8'(8'h50 + k - 3), 1'b1);
    end

    // Randomized phase
    begin
      logic [SELW-1:0] rs;
      rs = 4'd3;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 15) == 0) rs = SELW'($urandom_range(0, 15));
        drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              WIDTH'($urandom), rs);
        rst = ($urandom_range(0, 199) == 0);
      end
      drive(1'b1, 1'b0, 8'h00, rs);
      rst = 1'b0;
      drive(1'b1, 1'b0, 8'h00, rs);
    end

    @(negedge clk);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
